// File: rtl/mem_arbiter_if.sv
// Bus bundle between the processor ports, the shared single-port memory and mem_arbiter.
// Handshake: a requester raises x_req with stable address/data and holds them until the
// cycle in which x_gnt is 1; that cycle is the transfer. A load returns x_rvalid for
// exactly one cycle, two cycles after its grant, with x_rdata valid in that cycle.
interface mem_arbiter_if #(
    parameter int AW = 10,
    parameter int DW = 32
);
    logic          halted;

    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;

    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic          busy;

    modport slave (
        input  halted, if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, busy
    );

    modport master (
        output halted, if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates one single-port memory between an instruction-fetch port and a data port.
// Data has priority, bounded by a streak counter so a waiting fetch is never starved.
module mem_arbiter #(
    parameter int AW         = 10,
    parameter int DW         = 32,
    parameter int STREAK_MAX = 4
) (
    input  logic                              clk1,
    input  logic                              rst_n,
    mem_arbiter_if.slave                      bus,
    output logic [1:0]                        owner_dbg,
    output logic [$clog2(STREAK_MAX+1)-1:0]   streak_dbg
);
    localparam int CW = $clog2(STREAK_MAX + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_IF   = 2'd1,
        ST_DATA = 2'd2
    } owner_e;

    owner_e        state, state_nx;
    logic          d_rd_tag;
    logic [CW-1:0] streak, streak_nx;

    logic          fetch_ok;
    logic          streak_full;
    logic          gnt_if, gnt_d, gnt_any;

    logic          if_rvalid_q, d_rvalid_q;
    logic [DW-1:0] if_rdata_q, d_rdata_q;

    assign fetch_ok    = bus.if_req && !bus.halted;
    assign streak_full = (streak == CW'(STREAK_MAX));

    // Grant decision and next owner; nothing is granted while reset is held.
    always_comb begin
        gnt_if   = 1'b0;
        gnt_d    = 1'b0;
        state_nx = ST_IDLE;
        if (rst_n) begin
            if (fetch_ok && (streak_full || !bus.d_req)) begin
                gnt_if = 1'b1;
            end else if (bus.d_req) begin
                gnt_d = 1'b1;
            end
        end
        if (gnt_if) begin
            state_nx = ST_IF;
        end else if (gnt_d) begin
            state_nx = ST_DATA;
        end
    end

    assign gnt_any = gnt_if || gnt_d;

    // Streak only counts data wins that actually made a live fetch wait.
    always_comb begin
        streak_nx = streak;
        if (!fetch_ok || gnt_if) begin
            streak_nx = '0;
        end else if (gnt_d && !streak_full) begin
            streak_nx = streak + CW'(1);
        end
    end

    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            d_rd_tag    <= 1'b0;
            streak      <= '0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            state       <= state_nx;
            d_rd_tag    <= gnt_d && !bus.d_we;
            streak      <= streak_nx;
            // The memory word for last cycle's read is on mem_rdata now.
            if_rvalid_q <= (state == ST_IF);
            d_rvalid_q  <= (state == ST_DATA) && d_rd_tag;
            if (state == ST_IF) begin
                if_rdata_q <= bus.mem_rdata;
            end
            if ((state == ST_DATA) && d_rd_tag) begin
                d_rdata_q <= bus.mem_rdata;
            end
        end
    end

    assign bus.if_gnt    = gnt_if;
    assign bus.d_gnt     = gnt_d;
    assign bus.mem_en    = gnt_any;
    assign bus.mem_we    = gnt_d && bus.d_we;
    assign bus.mem_addr  = gnt_if ? bus.if_addr : (gnt_d ? bus.d_addr : '0);
    assign bus.mem_wdata = gnt_any ? bus.d_wdata : '0;

    assign bus.if_rvalid = if_rvalid_q;
    assign bus.d_rvalid  = d_rvalid_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;

    assign bus.busy = gnt_any || (state == ST_IF) || ((state == ST_DATA) && d_rd_tag);

    assign owner_dbg  = state;
    assign streak_dbg = streak;

    a_one_grant : assert property (@(posedge clk1) !(gnt_if && gnt_d));
    a_halt_no_if : assert property (@(posedge clk1) bus.halted |-> !gnt_if);
    a_streak_range : assert property (@(posedge clk1) streak <= CW'(STREAK_MAX));
endmodule
